// File: rtl/uart_cmd_decoder.sv
// UART command-frame decoder: assembles SOF/CMD/ARG_H/ARG_L/CHK frames from uart_rx,
// checks XOR checksum and inter-byte timeout, and strobes decoded commands to game logic.
module uart_cmd_decoder #(
   parameter logic [7:0]  SOF            = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_done_tick,
   input  logic [7:0]           dout,
   output logic                 cmd_valid,
   output logic [7:0]           cmd_id,
   output logic [15:0]          cmd_arg,
   output logic                 frame_err,
   output logic [1:0]           err_code,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 busy
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_CHK = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ARGH = 3'd2;
   localparam logic [2:0] S_ARGL = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;

   logic [2:0]       state,   state_next;
   logic [TMO_W-1:0] tmo_cnt, tmo_next;
   logic [7:0]       cmd_sh,  cmd_sh_next;
   logic [7:0]       argh_sh, argh_next;
   logic [7:0]       argl_sh, argl_next;
   logic [7:0]       chk,     chk_next;
   logic             good_c;
   logic             chk_err_c;
   logic             tmo_err_c;
   logic             err_c;

   // Next-state, shadow capture, checksum and timeout decisions
   always_comb begin
      state_next  = state;
      tmo_next    = tmo_cnt;
      cmd_sh_next = cmd_sh;
      argh_next   = argh_sh;
      argl_next   = argl_sh;
      chk_next    = chk;
      good_c      = 1'b0;
      chk_err_c   = 1'b0;
      tmo_err_c   = 1'b0;

      // A byte arriving on the expiry cycle wins over the timeout
      if (state == IDLE) begin
         tmo_next = '0;
      end else if (rx_done_tick) begin
         tmo_next = '0;
      end else if (tmo_cnt == TMO_LAST) begin
         tmo_next   = '0;
         tmo_err_c  = 1'b1;
         state_next = IDLE;
      end else begin
         tmo_next = tmo_cnt + TMO_W'(1);
      end

      case (state)
         IDLE: begin
            if (rx_done_tick && (dout == SOF)) begin
               state_next = S_CMD;
            end
         end
         S_CMD: begin
            if (rx_done_tick) begin
               cmd_sh_next = dout;
               chk_next    = dout;
               state_next  = S_ARGH;
            end
         end
         S_ARGH: begin
            if (rx_done_tick) begin
               argh_next  = dout;
               chk_next   = chk ^ dout;
               state_next = S_ARGL;
            end
         end
         S_ARGL: begin
            if (rx_done_tick) begin
               argl_next  = dout;
               chk_next   = chk ^ dout;
               state_next = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_done_tick) begin
               state_next = IDLE;
               if (dout == chk) begin
                  good_c = 1'b1;
               end else begin
                  chk_err_c = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign err_c = chk_err_c | tmo_err_c;

   // State, shadows and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         cmd_sh    <= '0;
         argh_sh   <= '0;
         argl_sh   <= '0;
         chk       <= '0;
         cmd_valid <= 1'b0;
         cmd_id    <= '0;
         cmd_arg   <= '0;
         frame_err <= 1'b0;
         err_code  <= '0;
         err_cnt   <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         tmo_cnt   <= tmo_next;
         cmd_sh    <= cmd_sh_next;
         argh_sh   <= argh_next;
         argl_sh   <= argl_next;
         chk       <= chk_next;
         cmd_valid <= good_c;
         frame_err <= err_c;
         busy      <= (state_next != IDLE);
         if (good_c) begin
            cmd_id  <= cmd_sh;
            cmd_arg <= {argh_sh, argl_sh};
         end
         if (chk_err_c) begin
            err_code <= ERR_CHK;
         end else if (tmo_err_c) begin
            err_code <= ERR_TMO;
         end
         // Saturating count; the pulse and code still update at the ceiling
         if (err_c && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (TIMEOUT_CYCLES reduced to 50).
module tb_uart_cmd_decoder;

   localparam int unsigned TMO = 50;

   logic        clk;
   logic        rst;
   logic        rx_done_tick;
   logic [7:0]  dout;
   logic        cmd_valid;
   logic [7:0]  cmd_id;
   logic [15:0] cmd_arg;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  err_cnt;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   uart_cmd_decoder #(
      .SOF            (8'hA5),
      .TIMEOUT_CYCLES (TMO),
      .ERR_CNT_W      (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .cmd_valid    (cmd_valid),
      .cmd_id       (cmd_id),
      .cmd_arg      (cmd_arg),
      .frame_err    (frame_err),
      .err_code     (err_code),
      .err_cnt      (err_cnt),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: one-cycle tick, returns at the negedge after it was sampled, plus gap
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_done_tick = 1'b1;
      dout         = b;
      @(negedge clk);
      rx_done_tick = 1'b0;
      dout         = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      int n;
      logic [7:0] exp_cnt;

      rst          = 1'b1;
      rx_done_tick = 1'b0;
      dout         = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      check("rst_cmd_id",    32'(cmd_id),    32'h0);
      check("rst_cmd_arg",   32'(cmd_arg),   32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_err_code",  32'(err_code),  32'h0);
      check("rst_err_cnt",   32'(err_cnt),   32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Good frame A5 10 12 34 36
      send_byte(8'hA5, 3);
      check("f1_busy", 32'(busy), 32'h1);
      send_byte(8'h10, 3);
      send_byte(8'h12, 3);
      send_byte(8'h34, 3);
      send_byte(8'h36, 0);
      check("f1_cmd_valid", 32'(cmd_valid), 32'h1);
      check("f1_cmd_id",    32'(cmd_id),    32'h10);
      check("f1_cmd_arg",   32'(cmd_arg),   32'h1234);
      check("f1_frame_err", 32'(frame_err), 32'h0);
      check("f1_err_cnt",   32'(err_cnt),   32'h0);
      check("f1_busy_low",  32'(busy),      32'h0);
      @(negedge clk);
      check("f1_pulse_end", 32'(cmd_valid), 32'h0);

      // Bad checksum A5 10 12 34 37
      send_byte(8'hA5, 2);
      send_byte(8'h10, 2);
      send_byte(8'h12, 2);
      send_byte(8'h34, 2);
      send_byte(8'h37, 0);
      check("f2_cmd_valid", 32'(cmd_valid), 32'h0);
      check("f2_frame_err", 32'(frame_err), 32'h1);
      check("f2_err_code",  32'(err_code),  32'h1);
      check("f2_err_cnt",   32'(err_cnt),   32'h1);
      check("f2_cmd_id",    32'(cmd_id),    32'h10);
      check("f2_cmd_arg",   32'(cmd_arg),   32'h1234);
      @(negedge clk);
      check("f2_pulse_end", 32'(frame_err), 32'h0);

      // Timeout: A5 10 then silence; error lands TMO cycles after the last tick
      send_byte(8'hA5, 2);
      send_byte(8'h10, 0);
      n = 0;
      for (int i = 1; i <= int'(TMO) + 5; i++) begin
         @(negedge clk);
         if (frame_err) begin
            n = i;
            break;
         end
      end
      check("tmo_latency",  32'(n),        32'(TMO));
      check("tmo_err_code", 32'(err_code), 32'h2);
      check("tmo_err_cnt",  32'(err_cnt),  32'h2);
      check("tmo_busy",     32'(busy),     32'h0);
      check("tmo_cmd_valid",32'(cmd_valid),32'h0);
      @(negedge clk);

      // Bytes landing exactly on the expiry cycle win: A5 01 00 FF FE
      send_byte(8'hA5, TMO - 1);
      send_byte(8'h01, TMO - 1);
      send_byte(8'h00, TMO - 1);
      send_byte(8'hFF, TMO - 1);
      check("edge_busy",      32'(busy),      32'h1);
      check("edge_no_err",    32'(frame_err), 32'h0);
      send_byte(8'hFE, 0);
      check("edge_cmd_valid", 32'(cmd_valid), 32'h1);
      check("edge_cmd_id",    32'(cmd_id),    32'h01);
      check("edge_cmd_arg",   32'(cmd_arg),   32'h00FF);
      check("edge_err_cnt",   32'(err_cnt),   32'h2);

      // Garbage ignored, then SOF-valued CMD and CHK bytes taken as data
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 1);
      check("garb_busy",    32'(busy),      32'h0);
      check("garb_err",     32'(frame_err), 32'h0);
      check("garb_err_cnt", 32'(err_cnt),   32'h2);
      send_byte(8'hA5, 1);
      send_byte(8'hA5, 1);
      send_byte(8'h00, 1);
      send_byte(8'h00, 1);
      send_byte(8'hA5, 0);
      check("sof_cmd_valid", 32'(cmd_valid), 32'h1);
      check("sof_cmd_id",    32'(cmd_id),    32'hA5);
      check("sof_cmd_arg",   32'(cmd_arg),   32'h0000);
      check("sof_err_code",  32'(err_code),  32'h2);

      // Reset mid-frame clears outputs immediately, no pulse for the aborted frame
      send_byte(8'hA5, 2);
      send_byte(8'h10, 2);
      send_byte(8'h12, 2);
      check("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",    32'(busy),     32'h0);
      check("mid_rst_cmd_id",  32'(cmd_id),   32'h0);
      check("mid_rst_cmd_arg", 32'(cmd_arg),  32'h0);
      check("mid_rst_err_cnt", 32'(err_cnt),  32'h0);
      check("mid_rst_err_code",32'(err_code), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("mid_no_pulse", 32'({cmd_valid, frame_err}), 32'h0);
      end
      send_byte(8'hA5, 1);
      send_byte(8'h20, 1);
      send_byte(8'hAB, 1);
      send_byte(8'hCD, 1);
      send_byte(8'h46, 0);
      check("post_cmd_valid", 32'(cmd_valid), 32'h1);
      check("post_cmd_id",    32'(cmd_id),    32'h20);
      check("post_cmd_arg",   32'(cmd_arg),   32'hABCD);
      check("post_err_cnt",   32'(err_cnt),   32'h0);

      // 260 back-to-back bad frames: counter saturates, pulse keeps firing
      for (int f = 0; f < 260; f++) begin
         send_byte(8'hA5, 0);
         send_byte(8'h01, 0);
         send_byte(8'h02, 0);
         send_byte(8'h03, 0);
         send_byte(8'hFF, 0);
         exp_cnt = (f >= 254) ? 8'hFF : 8'(f + 1);
         check("sat_frame_err", 32'(frame_err), 32'h1);
         check("sat_err_cnt",   32'(err_cnt),   32'(exp_cnt));
      end
      check("sat_err_code", 32'(err_code), 32'h1);
      check("sat_cmd_id",   32'(cmd_id),   32'h20);
      @(negedge clk);
      check("sat_final_cnt", 32'(err_cnt), 32'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
